// File: rtl/watch_pkg.sv
// Shared types, field limits and calendar helper for the watch time-setting block.
package watch_pkg;

    localparam int unsigned FIELD_W = 8;
    localparam int unsigned TIME_W  = 6 * FIELD_W;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        EDIT_YEAR  = 3'd1,
        EDIT_MONTH = 3'd2,
        EDIT_DAY   = 3'd3,
        EDIT_HOUR  = 3'd4,
        EDIT_MIN   = 3'd5,
        EDIT_SEC   = 3'd6,
        COMMIT     = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        FIELD_NONE   = 3'd0,
        FIELD_YEAR   = 3'd1,
        FIELD_MONTH  = 3'd2,
        FIELD_DAY    = 3'd3,
        FIELD_HOUR   = 3'd4,
        FIELD_MINUTE = 3'd5,
        FIELD_SECOND = 3'd6
    } field_e;

    typedef struct packed {
        logic [FIELD_W-1:0] year;
        logic [FIELD_W-1:0] month;
        logic [FIELD_W-1:0] day;
        logic [FIELD_W-1:0] hour;
        logic [FIELD_W-1:0] minute;
        logic [FIELD_W-1:0] second;
    } watch_time_t;

    localparam logic [FIELD_W-1:0] YEAR_MIN   = 8'd1;
    localparam logic [FIELD_W-1:0] YEAR_MAX   = 8'd255;
    localparam logic [FIELD_W-1:0] MONTH_MIN  = 8'd1;
    localparam logic [FIELD_W-1:0] MONTH_MAX  = 8'd12;
    localparam logic [FIELD_W-1:0] DAY_MIN    = 8'd1;
    localparam logic [FIELD_W-1:0] HOUR_MIN   = 8'd0;
    localparam logic [FIELD_W-1:0] HOUR_MAX   = 8'd23;
    localparam logic [FIELD_W-1:0] MINUTE_MIN = 8'd0;
    localparam logic [FIELD_W-1:0] MINUTE_MAX = 8'd59;
    localparam logic [FIELD_W-1:0] SECOND_MIN = 8'd0;
    localparam logic [FIELD_W-1:0] SECOND_MAX = 8'd59;

    localparam watch_time_t RESET_TIME = '{
        year: 8'd21, month: 8'd5, day: 8'd30, hour: 8'd0, minute: 8'd0, second: 8'd0
    };

    // Days in month, no leap years; unknown months fall back to 31
    function automatic logic [FIELD_W-1:0] max_day(input logic [FIELD_W-1:0] month);
        case (month)
            8'd2:                    return 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11: return 8'd30;
            default:                 return 8'd31;
        endcase
    endfunction

endpackage

// File: rtl/watch_field_step.sv
// Wrapping up/down step of one time field; out-of-range inputs snap to the minimum.
module watch_field_step
    import watch_pkg::*;
(
    input  logic [FIELD_W-1:0] value,
    input  logic [FIELD_W-1:0] min_val,
    input  logic [FIELD_W-1:0] max_val,
    input  logic               up,
    input  logic               down,
    output logic [FIELD_W-1:0] next_value_c
);

    always_comb begin
        next_value_c = value;
        if ((value < min_val) || (value > max_val)) begin
            if (up || down) next_value_c = min_val;
        end else if (up) begin
            next_value_c = (value == max_val) ? min_val : value + FIELD_W'(1);
        end else if (down) begin
            next_value_c = (value == min_val) ? max_val : value - FIELD_W'(1);
        end
    end

endmodule

// File: rtl/watch_time_setter.sv
// Button-driven date/time editor: snapshots live time, steps one field at a time,
// and strobes the edited value back to the watch counter on commit.
module watch_time_setter
    import watch_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk1sec,
    input  logic              btn_mode,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic [7:0]        cur_year,
    input  logic [7:0]        cur_month,
    input  logic [7:0]        cur_day,
    input  logic [7:0]        cur_hour,
    input  logic [7:0]        cur_minute,
    input  logic [7:0]        cur_second,
    output logic [TIME_W-1:0] bin_time,
    output logic              set_time,
    output logic              editing,
    output logic [2:0]        edit_field,
    output logic              blink
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_SEC + 1);

    state_e             state, state_next;
    watch_time_t        edit_q, edit_next;
    logic [TMO_W-1:0]   tmo_q, tmo_next;
    logic               blink_next, set_time_next, editing_next;
    logic [2:0]         edit_field_next;
    logic [FIELD_W-1:0] field_val, field_min, field_max, step_val;
    logic               step_up, step_down, step_en, any_btn;

    // Simultaneous up+down cancel; mode takes precedence over both
    assign step_up   = btn_up & ~btn_down & ~btn_mode;
    assign step_down = btn_down & ~btn_up & ~btn_mode;
    assign step_en   = step_up | step_down;
    assign any_btn   = btn_mode | btn_up | btn_down;

    always_comb begin
        field_val = edit_q.year;
        field_min = YEAR_MIN;
        field_max = YEAR_MAX;
        case (state)
            EDIT_MONTH: begin field_val = edit_q.month;  field_min = MONTH_MIN;  field_max = MONTH_MAX;  end
            EDIT_DAY:   begin field_val = edit_q.day;    field_min = DAY_MIN;    field_max = max_day(edit_q.month); end
            EDIT_HOUR:  begin field_val = edit_q.hour;   field_min = HOUR_MIN;   field_max = HOUR_MAX;   end
            EDIT_MIN:   begin field_val = edit_q.minute; field_min = MINUTE_MIN; field_max = MINUTE_MAX; end
            EDIT_SEC:   begin field_val = edit_q.second; field_min = SECOND_MIN; field_max = SECOND_MAX; end
            default: ;
        endcase
    end

    watch_field_step u_step (
        .value        (field_val),
        .min_val      (field_min),
        .max_val      (field_max),
        .up           (step_up),
        .down         (step_down),
        .next_value_c (step_val)
    );

    always_comb begin
        state_next = state;
        edit_next  = edit_q;
        tmo_next   = tmo_q;
        blink_next = blink;
        case (state)
            IDLE: begin
                tmo_next = '0;
                if (btn_mode) begin
                    edit_next = '{year: cur_year, month: cur_month, day: cur_day,
                                  hour: cur_hour, minute: cur_minute, second: cur_second};
                    state_next = EDIT_YEAR;
                end
            end
            COMMIT: begin
                tmo_next   = '0;
                state_next = IDLE;
            end
            default: begin
                if (btn_mode) begin
                    state_next = state_e'(3'(state + 3'd1));
                end else if (step_en) begin
                    case (state)
                        EDIT_YEAR:  edit_next.year = step_val;
                        EDIT_MONTH: begin
                            edit_next.month = step_val;
                            if (edit_q.day > max_day(step_val)) edit_next.day = max_day(step_val);
                        end
                        EDIT_DAY:   edit_next.day    = step_val;
                        EDIT_HOUR:  edit_next.hour   = step_val;
                        EDIT_MIN:   edit_next.minute = step_val;
                        default:    edit_next.second = step_val;
                    endcase
                end
                // Idle timeout: any press restarts the count
                if (any_btn) begin
                    tmo_next = '0;
                end else if (clk1sec) begin
                    if (tmo_q == TMO_W'(TIMEOUT_SEC - 1)) begin
                        tmo_next   = '0;
                        state_next = IDLE;
                    end else begin
                        tmo_next = tmo_q + TMO_W'(1);
                    end
                end
                if (btn_up || btn_down) blink_next = 1'b1;
                else if (clk1sec)       blink_next = ~blink;
            end
        endcase
        set_time_next   = (state_next == COMMIT);
        editing_next    = (state_next != IDLE) && (state_next != COMMIT);
        edit_field_next = editing_next ? 3'(state_next) : 3'(FIELD_NONE);
        if (!editing_next) blink_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            edit_q     <= RESET_TIME;
            tmo_q      <= '0;
            blink      <= 1'b0;
            set_time   <= 1'b0;
            editing    <= 1'b0;
            edit_field <= 3'd0;
        end else begin
            state      <= state_next;
            edit_q     <= edit_next;
            tmo_q      <= tmo_next;
            blink      <= blink_next;
            set_time   <= set_time_next;
            editing    <= editing_next;
            edit_field <= edit_field_next;
        end
    end

    assign bin_time = edit_q;

endmodule
